// File: rtl/dcache_mem_stage.sv
// Memory-access pipeline stage with a direct-mapped, write-through, no-write-allocate
// data cache in front of a single-word request/ready main-memory port.
module dcache_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   ALUResult_m,
  input  logic [DATA_WIDTH-1:0]   WriteData_m,
  input  logic                    MemRead_m,
  input  logic                    MemWrite_m,
  input  logic [2:0]              funct3_m,
  output logic [DATA_WIDTH-1:0]   ReadData_m,
  output logic                    valid_m,
  output logic                    stall_m,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = IDX_W + WORD_W + 2;
  localparam int TAG_W   = DATA_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       beat_q, beat_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_q [LINES][WORDS_PER_LINE];

  logic [1:0]              off_s;
  logic [WORD_W-1:0]       word_s;
  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic                    hit_s;
  logic                    is_load_s;
  logic                    is_store_s;
  logic                    miss_s;
  logic                    fill_we_s;
  logic                    fill_done_s;
  logic                    store_we_s;

  function automatic logic [NB-1:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [NB-1:0] strb;
    case (f3)
      3'b000:  strb = {{(NB-1){1'b0}}, 1'b1} << off;
      3'b001:  strb = {{(NB-2){1'b0}}, 2'b11} << {off[1], 1'b0};
      default: strb = {NB{1'b1}};
    endcase
    return strb;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] lanes;
    case (f3)
      3'b000:  lanes = {NB{wd[7:0]}};
      3'b001:  lanes = {(NB/2){wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] off,
                                                        input logic [2:0] f3);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign off_s      = ALUResult_m[1:0];
  assign word_s     = ALUResult_m[WORD_W+1:2];
  assign idx_s      = ALUResult_m[TAG_LSB-1:WORD_W+2];
  assign tag_s      = ALUResult_m[DATA_WIDTH-1:TAG_LSB];
  assign hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign is_load_s  = valid_in & MemRead_m;
  assign is_store_s = valid_in & MemWrite_m;
  assign ReadData_m = load_extend(data_q[idx_s][word_s], off_s, funct3_m);

  // next-state, handshake and pipeline-control decode
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    valid_m     = 1'b0;
    stall_m     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    miss_s      = 1'b0;
    fill_we_s   = 1'b0;
    fill_done_s = 1'b0;
    store_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_load_s) begin
          if (hit_s) begin
            valid_m = 1'b1;
          end else begin
            stall_m = 1'b1;
            miss_s  = 1'b1;
            beat_d  = '0;
            state_d = S_REFILL;
          end
        end else if (is_store_s) begin
          stall_m = 1'b1;
          state_d = S_WRITE;
        end else begin
          valid_m = valid_in;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        stall_m  = 1'b1;
        mem_addr = {tag_s, idx_s, beat_q, 2'b00};
        if (mem_ready) begin
          fill_we_s = 1'b1;
          beat_d    = beat_q + WORD_W'(1);
          if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) begin
            fill_done_s = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};
        mem_wdata = store_lanes(funct3_m, WriteData_m);
        mem_wstrb = store_strobe(funct3_m, off_s);
        if (mem_ready) begin
          valid_m    = 1'b1;
          store_we_s = hit_s;
          state_d    = S_IDLE;
        end else begin
          stall_m = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, beat counter and line valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      // a line being refilled stays invalid until its last beat lands
      if (miss_s) begin
        valid_q[idx_s] <= 1'b0;
      end else if (fill_done_s) begin
        valid_q[idx_s] <= 1'b1;
      end
    end
  end

  // tag and data storage: refill beats and write-through hit updates
  always_ff @(posedge clk) begin
    if (!rst && fill_we_s) begin
      data_q[idx_s][beat_q] <= mem_rdata;
    end
    if (!rst && fill_done_s) begin
      tag_q[idx_s] <= tag_s;
    end
    if (!rst && store_we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wstrb[b]) begin
          data_q[idx_s][word_s][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dcache_mem_stage.md
# dcache_mem_stage

Memory-access stage of the pipelined-plus-cache core: sits between the EX/MEM pipeline register and the MEM/WB register, taking the effective address and store data and producing `ReadData_m`/`valid_m`. Contains a direct-mapped, write-through, no-write-allocate data cache backed by a single-word request/ready main-memory port. It stalls the front of the pipeline via `stall_m` on load misses and on every store until main memory accepts the write.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data and address width.
- `LINES`, 16, cache lines (power of 2).
- `WORDS_PER_LINE`, 4, words per line (power of 2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `valid_in`  in  1  EX/MEM holds a valid instruction.
- `ALUResult_m`  in  32  effective byte address.
- `WriteData_m`  in  32  store data, right-aligned.
- `MemRead_m`  in  1  instruction is a load.
- `MemWrite_m`  in  1  instruction is a store. `MemRead_m` and `MemWrite_m` are never both set.
- `funct3_m`  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ReadData_m`  out  32  extended load result.
- `valid_m`  out  1  instruction completes this cycle; feeds MEM/WB `valid_m`.
- `stall_m`  out  1  hold upstream stages; upstream `en = ~stall_m`.
- `mem_req`  out  1  main-memory request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  32  word-aligned address, with `[1:0] = 0`.
- `mem_wdata`  out  32  write data, lane-aligned.
- `mem_wstrb`  out  4  byte strobes.
- `mem_ready`  in  1  request accepted. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.

## Operation
**Address split**
- offset `[1:0]`.
- word `[log2(WPL)+1:2]`.
- index next `log2(LINES)` bits.
- tag = remaining upper bits.

**Storage**
- Per line: valid bit, tag, WPL words.
- Arrays are flop-based with asynchronous read.

**FSM states: IDLE, REFILL, WRITE**
- IDLE, no memory op (`valid_in` = 0, or neither `MemRead_m` nor `MemWrite_m`): `valid_m = valid_in`, `stall_m` = 0.
- IDLE, load hit (valid bit set and tags equal): `ReadData_m` is driven combinationally, `valid_m` = 1, `stall_m` = 0.
- IDLE, load miss: `stall_m` = 1, `valid_m` = 0. Next state REFILL with beat counter = 0.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, beat, 00}.
  - On `mem_ready`, write `mem_rdata` into word[beat] and increment beat.
  - On the last beat: set the valid bit, write the tag, go to IDLE.
  - The re-lookup in IDLE then hits.
  - `stall_m` = 1 throughout.
- IDLE, store (hit or miss): `stall_m` = 1. Next state WRITE.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `mem_addr` = address with `[1:0]` cleared.
  - `mem_wdata` = `WriteData_m` replicated to lanes.
  - `mem_wstrb`: SB gives `4'b0001 << off`; SH gives `4'b0011 << {off[1],0}`; SW gives `4'b1111`.
  - On `mem_ready`: if the line hits, update the strobed bytes in the cache. Then `valid_m` = 1, `stall_m` = 0, next state IDLE.
  - Store miss does not allocate.

**Load extraction**
- B/BU select byte `off`; H/HU select half `off[1]`; W ignores `off`.
- B and H sign-extend; BU and HU zero-extend.
- Misaligned accesses are truncated as stated above; no exception is raised.

**Idle memory port**
- `mem_req` = 1 only in REFILL and WRITE.
- In IDLE, `mem_we`, `mem_wstrb` and `mem_wdata` are 0.

## Timing
**Reset** (the edge with `rst` = 1):
- State → IDLE, beat → 0, all valid bits cleared.
- Outputs in the following cycle: `mem_req` 0, `stall_m` 0 (unless a miss is presented), `valid_m` = `valid_in` for non-memory ops.
- Reset during REFILL or WRITE abandons the transfer. The partially filled line stays invalid, and memory ignores the withdrawn request.

**Latency with `mem_ready` tied high**
- Load hit: 0 stall cycles.
- Load miss: `stall_m` high for 1 + WPL cycles (5). Result in cycle 5, counted from the miss cycle 0.
- Store: `stall_m` high for 1 cycle; `valid_m` in cycle 1.

**Handshake**
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable while `mem_req` is high and `mem_ready` is low.
- Each `mem_ready` cycle extends nothing else: one beat per ready.

**Stall behaviour**
- While `stall_m` = 1, upstream inputs are held constant.
- `valid_m` is 0 during every stall cycle.

**Beat counter**
- Width `log2(WPL)`.
- Wraps to 0 after the last beat.

## Test plan
1. **Cold LW miss.**
   - Stimulus: after reset, LW at 0x100; memory returns 0xA0..0xA3 (one per beat) with `mem_ready` = 1.
   - Response: `mem_addr` = 0x100, 0x104, 0x108, 0x10C; `stall_m` high for 5 cycles; cycle 5 gives `valid_m` = 1, `ReadData_m` = 0xA0.
   - Follow-up: LW 0x108 in the next cycle → hit with 0 stall, result 0xA2.
2. **Store hit.**
   - Stimulus: line 0x100 resident; SB `WriteData_m` = 0x000000FF to 0x103; `mem_ready` delayed 3 cycles.
   - Response: `mem_wstrb` = 1000, `mem_wdata` = 0xFFFFFFFF held 4 cycles; `valid_m` in the ready cycle.
   - Follow-up: LB 0x103 → 0xFFFFFFFF; LBU 0x103 → 0x000000FF.
3. **Store miss.**
   - Stimulus: SW 0x2000 = 0x12345678, line not resident.
   - Response: one write with `mem_wstrb` = 1111; no refill.
   - Follow-up: LW 0x2000 → refill occurs.
4. **Conflict eviction.**
   - Stimulus: LW 0x100, then LW 0x500 (same index, different tag).
   - Response: second access refills. Follow-up: LW 0x100 misses again.
5. **Reset mid-REFILL.**
   - Stimulus: assert `rst` after beat 2 of a miss.
   - Response: next cycle `mem_req` = 0, state IDLE. Follow-up: LW of the same address misses and refills all 4 beats.
6. **Non-memory passthrough.**
   - Stimulus: `valid_in` = 1 with `MemRead_m` = `MemWrite_m` = 0 for 3 cycles.
   - Response: `valid_m` = 1, `stall_m` = 0, `mem_req` = 0 each cycle.
